// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: datapath widths, multiply/divide
// op encodings and the multiply/divide sequencer state encoding.
package risc_pkg;
    localparam int WIDTH  = 16;
    localparam int RIDX_W = 4;

    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHI = 2'b01,
        OP_DIVQ  = 2'b10,
        OP_DIVR  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_WB   = 2'b10
    } state_t;
endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request / register-file write-back bundle for the multiply/divide unit.
interface muldiv_unit_if;
    import risc_pkg::*;

    logic                start;
    logic [1:0]          op;
    logic [RIDX_W-1:0]   Rd_in;
    logic [WIDTH-1:0]    A;
    logic [WIDTH-1:0]    B;
    logic                busy;
    logic                done;
    logic [RIDX_W-1:0]   Rd;
    logic [WIDTH-1:0]    RW;
    logic                wr;

    modport master (
        output start, op, Rd_in, A, B,
        input  busy, done, Rd, RW, wr
    );

    modport slave (
        input  start, op, Rd_in, A, B,
        output busy, done, Rd, RW, wr
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) unit, one bit per
// cycle, finishing with a single register-file write-back cycle.
module muldiv_unit
    import risc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH);

    state_t             state_reg;
    logic [CW-1:0]      cnt_reg;
    op_t                op_reg;
    logic               div0_reg;
    logic [W-1:0]       opnd_reg;
    logic [2*W-1:0]     acc_reg;
    logic [RIDX_W-1:0]  rd_lat_reg;
    logic [RIDX_W-1:0]  rd_reg;
    logic [W-1:0]       rw_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               wr_reg;

    logic [W:0]         mul_sum;
    logic [W:0]         div_shift;
    logic [W:0]         div_trial;
    logic [2*W-1:0]     acc_next;
    logic [W-1:0]       result_next;

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}});
        div_shift = acc_reg[2*W-1:W-1];
        div_trial = div_shift - {1'b0, opnd_reg};
        acc_next  = {mul_sum, acc_reg[W-1:1]};
        if (op_reg[1]) begin
            if (div_trial[W]) begin
                acc_next = {div_shift[W-1:0], acc_reg[W-2:0], 1'b0};
            end else begin
                acc_next = {div_trial[W-1:0], acc_reg[W-2:0], 1'b1};
            end
        end
        // High half is the MUL high word or the remainder; low half the MUL low word or quotient.
        result_next = op_reg[0] ? acc_next[2*W-1:W] : acc_next[W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            op_reg     <= OP_MULLO;
            div0_reg   <= 1'b0;
            opnd_reg   <= '0;
            acc_reg    <= '0;
            rd_lat_reg <= '0;
            rd_reg     <= '0;
            rw_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            wr_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        op_reg     <= op_t'(bus.op);
                        rd_lat_reg <= bus.Rd_in;
                        cnt_reg    <= '0;
                        div0_reg   <= bus.op[1] && (bus.B == '0);
                        opnd_reg   <= bus.op[1] ? bus.B : bus.A;
                        acc_reg    <= {{W{1'b0}}, (bus.op[1] ? bus.A : bus.B)};
                        busy_reg   <= 1'b1;
                        state_reg  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (div0_reg) begin
                        // Divide by zero skips iteration; the dividend still sits in acc's low half.
                        rw_reg    <= op_reg[0] ? acc_reg[W-1:0] : {W{1'b1}};
                        rd_reg    <= rd_lat_reg;
                        wr_reg    <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= S_WB;
                    end else begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CW'(W - 1)) begin
                            rw_reg    <= result_next;
                            rd_reg    <= rd_lat_reg;
                            wr_reg    <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    wr_reg    <= 1'b0;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.wr   = wr_reg;
    assign bus.Rd   = rd_reg;
    assign bus.RW   = rw_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, hand-written corner sequences,
// and a scoreboard that checks every write-back's index, data and cycle.
module tb_muldiv_unit;
    import risc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if bus ();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] rw;
        int          wcyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  rd;
        logic [15:0] res;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Write-back monitor: every wr cycle must match the oldest expected transaction.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (bus.wr || bus.done)) begin
            chk("done_eq_wr", {31'd0, bus.done}, {31'd0, bus.wr});
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_wr actual=1 required=0 Rd=%h RW=%h (cycle %0d)", bus.Rd, bus.RW, cyc);
            end else begin
                e = sb.pop_front();
                $display("WB  Rd=%0d RW=%h cycle=%0d", bus.Rd, bus.RW, cyc);
                chk("wb_rd",    {28'd0, bus.Rd}, {28'd0, e.rd});
                chk("wb_rw",    {16'd0, bus.RW}, {16'd0, e.rw});
                chk("wb_cycle", cyc, e.wcyc);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 1, 0);
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] rd);
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.Rd_in = rd;
        bus.start = 1'b1;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] rd, input logic [15:0] res);
        int   n;
        int   n0;
        logic div0;
        exp_t e;
        wait_idle();
        @(negedge clk);
        drive(op, a, b, rd);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 16'($urandom);
        bus.B     = 16'($urandom);
        n0        = cyc;
        div0      = op[1] && (b == 16'h0);
        e.rd      = rd;
        e.rw      = res;
        e.wcyc    = n0 + (div0 ? 1 : 16);
        sb.push_back(e);
        $display("OP  op=%0d A=%h B=%h Rd=%0d expect=%h accept=%0d", op, a, b, rd, res, n0);
        chk("busy_at_accept", {31'd0, bus.busy}, 32'd1);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, div0 ? 2 : 17);
        @(negedge clk);
        chk("rw_hold", {16'd0, bus.RW}, {16'd0, res});
        chk("rd_hold", {28'd0, bus.Rd}, {28'd0, rd});
    endtask

    vec_t vecs[14];

    initial begin
        int          n0;
        int          n;
        exp_t        e;
        logic [1:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] prod;
        logic [15:0] rres;

        vecs[0]  = '{2'b00, 16'h0123, 16'h0045, 4'd3,  16'h4E6F};
        vecs[1]  = '{2'b01, 16'hFFFF, 16'hFFFF, 4'd4,  16'hFFFE};
        vecs[2]  = '{2'b00, 16'hFFFF, 16'hFFFF, 4'd5,  16'h0001};
        vecs[3]  = '{2'b10, 16'h03E8, 16'h0007, 4'd6,  16'h008E};
        vecs[4]  = '{2'b11, 16'h03E8, 16'h0007, 4'd7,  16'h0006};
        vecs[5]  = '{2'b10, 16'h1234, 16'h0000, 4'd8,  16'hFFFF};
        vecs[6]  = '{2'b11, 16'h1234, 16'h0000, 4'd9,  16'h1234};
        vecs[7]  = '{2'b01, 16'h1234, 16'h5678, 4'd10, 16'h0626};
        vecs[8]  = '{2'b00, 16'h1234, 16'h5678, 4'd11, 16'h0060};
        vecs[9]  = '{2'b10, 16'hFFFF, 16'h0001, 4'd12, 16'hFFFF};
        vecs[10] = '{2'b11, 16'hFFFF, 16'h0001, 4'd13, 16'h0000};
        vecs[11] = '{2'b10, 16'h0005, 16'h0007, 4'd14, 16'h0000};
        vecs[12] = '{2'b11, 16'h0005, 16'h0007, 4'd15, 16'h0005};
        vecs[13] = '{2'b10, 16'h8000, 16'h8000, 4'd1,  16'h0001};

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        bus.Rd_in = '0;
        #12;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_wr",   {31'd0, bus.wr},   32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_rd",   {28'd0, bus.Rd},   32'd0);
        chk("reset_rw",   {16'd0, bus.RW},   32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res);
        end

        // Randomised operands against a bench-side arithmetic model.
        for (int i = 0; i < 6; i++) begin
            rop  = 2'($urandom);
            ra   = 16'($urandom);
            rb   = (i == 2) ? 16'h0 : 16'($urandom_range(0, 16'hFFFF));
            prod = {16'h0, ra} * {16'h0, rb};
            case (rop)
                2'b00:   rres = prod[15:0];
                2'b01:   rres = prod[31:16];
                2'b10:   rres = (rb == 0) ? 16'hFFFF : ra / rb;
                default: rres = (rb == 0) ? ra : ra % rb;
            endcase
            do_op(rop, ra, rb, 4'(i), rres);
        end

        // Start pulse with different operands during CALC must be ignored.
        wait_idle();
        @(negedge clk);
        drive(2'b00, 16'h0123, 16'h0045, 4'd2);
        @(negedge clk);
        bus.start = 1'b0;
        n0        = cyc;
        e.rd = 4'd2; e.rw = 16'h4E6F; e.wcyc = n0 + 16;
        sb.push_back(e);
        $display("OP  busy-protect accept=%0d", n0);
        repeat (4) @(negedge clk);
        drive(2'b10, 16'h0064, 16'h0003, 4'd9);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        chk("busy_protect_idle", {31'd0, bus.busy}, 32'd0);

        // Start held high: second accept exactly at N+18.
        @(negedge clk);
        drive(2'b11, 16'h03E8, 16'h0007, 4'd5);
        @(negedge clk);
        n0 = cyc;
        e.rd = 4'd5; e.rw = 16'h0006; e.wcyc = n0 + 16;
        sb.push_back(e);
        e.wcyc = n0 + 34;
        sb.push_back(e);
        $display("OP  back-to-back accept=%0d", n0);
        n = 0;
        while (cyc < n0 + 18 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("b2b_second_accept", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        wait_idle();

        // Asynchronous reset in the middle of CALC aborts without write-back.
        @(negedge clk);
        drive(2'b01, 16'hFFFF, 16'hFFFF, 4'd7);
        @(negedge clk);
        bus.start = 1'b0;
        n0 = cyc;
        $display("OP  reset-abort accept=%0d", n0);
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_wr",   {31'd0, bus.wr},   32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_idle", {31'd0, bus.busy}, 32'd0);
        do_op(2'b00, 16'h0123, 16'h0045, 4'd3, 16'h4E6F);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
